// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, alu_op encodings and control bundle for pipe_ctrl_unit
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    // Non-zero so a decoded ADD is distinguishable from a bubble.
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_FUNCT = 3'd3;
    localparam logic [2:0] ALU_LINK  = 3'd4;

    // MULT occupancy counter, wide enough for latencies up to 15.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       alu_src;
        logic [2:0] alu_op;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    localparam int EX_HI  = 10;
    localparam int EX_LO  = 4;
    localparam int MEM_HI = 3;
    localparam int MEM_LO = 2;
    localparam int WB_HI  = 1;
    localparam int WB_LO  = 0;

endpackage

// File: rtl/mips_main_decoder.sv
// rtl/mips_main_decoder.sv - combinational opcode/funct to control bundle decoder
//  opcode/funct/rt/rd in; ctrl bundle, dst, illegal, reads_rt, is_mult, ext_sign out.
module mips_main_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W  = 6,
    parameter int FN_W   = 6,
    parameter int RA_W   = 5,
    parameter bit EN_JAL = 1'b1
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [FN_W-1:0]  funct,
    input  logic [RA_W-1:0]  rt,
    input  logic [RA_W-1:0]  rd,
    output ctrl_t            ctrl,
    output logic [RA_W-1:0]  dst,
    output logic             illegal,
    output logic             reads_rt,
    output logic             is_mult,
    output logic             ext_sign
);

    always_comb begin
        ctrl     = '0;
        dst      = '0;
        illegal  = 1'b0;
        reads_rt = 1'b0;
        is_mult  = 1'b0;
        ext_sign = !((opcode == OPC_W'(OP_ANDI)) || (opcode == OPC_W'(OP_ORI)));

        case (opcode)
            OPC_W'(OP_RTYPE): begin
                reads_rt = 1'b1;
                case (funct)
                    FN_W'(FN_SLL), FN_W'(FN_SRL), FN_W'(FN_SRA), FN_W'(FN_MULT),
                    FN_W'(FN_ADD), FN_W'(FN_ADDU), FN_W'(FN_SUB), FN_W'(FN_SUBU),
                    FN_W'(FN_AND), FN_W'(FN_OR), FN_W'(FN_XOR), FN_W'(FN_NOR),
                    FN_W'(FN_SLT), FN_W'(FN_SLTU): begin
                        ctrl.alu_op    = ALU_FUNCT;
                        ctrl.reg_write = 1'b1;
                        dst            = rd;
                        is_mult        = (funct == FN_W'(FN_MULT));
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_W'(OP_LW): begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                dst             = rt;
            end
            OPC_W'(OP_SW): begin
                reads_rt       = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OPC_W'(OP_BEQ), OPC_W'(OP_BNE): begin
                reads_rt    = 1'b1;
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                ctrl.bne    = (opcode == OPC_W'(OP_BNE));
            end
            OPC_W'(OP_ADDI): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                dst            = rt;
            end
            OPC_W'(OP_J): ctrl.jump = 1'b1;
            OPC_W'(OP_JAL): begin
                if (EN_JAL) begin
                    ctrl.jump      = 1'b1;
                    ctrl.alu_op    = ALU_LINK;
                    ctrl.reg_write = 1'b1;
                    dst            = RA_W'(31);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        // Register 0 is hardwired; writing it would be a no-op that could still trip forwarding.
        if (dst == '0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined control unit: decode, stage registers, load-use and MULT stalls
//  in: clk, rst_n, id_valid, id_opcode/funct/rs/rt/rd, flush
//  out: stall, ex_ctrl/ex_dst, mem_ctrl/mem_dst, wb_ctrl/wb_dst, ext_sign, illegal_op
module pipe_ctrl_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W      = 6,
    parameter int FN_W       = 6,
    parameter int RA_W       = 5,
    parameter int MULDIV_LAT = 4,
    parameter bit EN_JAL     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [FN_W-1:0]  id_funct,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             flush,
    output logic             stall,
    output logic [6:0]       ex_ctrl,
    output logic [RA_W-1:0]  ex_dst,
    output logic [1:0]       mem_ctrl,
    output logic [RA_W-1:0]  mem_dst,
    output logic [1:0]       wb_ctrl,
    output logic [RA_W-1:0]  wb_dst,
    output logic             ext_sign,
    output logic             illegal_op
);

    ctrl_t            dec_ctrl;
    logic [RA_W-1:0]  dec_dst;
    logic             dec_illegal;
    logic             dec_reads_rt;
    logic             dec_is_mult;

    ctrl_t            ex_c;
    logic [RA_W-1:0]  ex_d;
    logic [3:0]       mem_c;
    logic [RA_W-1:0]  mem_d;
    logic [1:0]       wb_c;
    logic [RA_W-1:0]  wb_d;
    logic [CNT_W-1:0] cnt;

    logic mult_busy;
    logic load_use;
    logic issue;

    mips_main_decoder #(
        .OPC_W  (OPC_W),
        .FN_W   (FN_W),
        .RA_W   (RA_W),
        .EN_JAL (EN_JAL)
    ) u_dec (
        .opcode   (id_opcode),
        .funct    (id_funct),
        .rt       (id_rt),
        .rd       (id_rd),
        .ctrl     (dec_ctrl),
        .dst      (dec_dst),
        .illegal  (dec_illegal),
        .reads_rt (dec_reads_rt),
        .is_mult  (dec_is_mult),
        .ext_sign (ext_sign)
    );

    always_comb begin
        mult_busy = (cnt != '0);
        load_use  = id_valid && ex_c.mem_read && (ex_d != '0) &&
                    ((ex_d == id_rs) || ((ex_d == id_rt) && dec_reads_rt));
        // A flushed instruction is discarded, so it cannot be waiting on the load.
        issue     = id_valid && !flush && !load_use;
        stall     = mult_busy || (load_use && !flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_c       <= '0;
            ex_d       <= '0;
            mem_c      <= '0;
            mem_d      <= '0;
            wb_c       <= '0;
            wb_d       <= '0;
            cnt        <= '0;
            illegal_op <= 1'b0;
        end else begin
            wb_c <= mem_c[WB_HI:WB_LO];
            wb_d <= mem_d;

            if (id_valid && !flush && dec_illegal) begin
                illegal_op <= 1'b1;
            end

            if (mult_busy) begin
                // EX keeps the MULT; downstream drains with bubbles.
                mem_c <= '0;
                mem_d <= '0;
                cnt   <= cnt - CNT_W'(1);
            end else begin
                mem_c <= ex_c[MEM_HI:WB_LO];
                mem_d <= ex_d;
                if (issue) begin
                    ex_c <= dec_ctrl;
                    ex_d <= dec_dst;
                    cnt  <= dec_is_mult ? CNT_W'(MULDIV_LAT - 1) : '0;
                end else begin
                    ex_c <= '0;
                    ex_d <= '0;
                    cnt  <= '0;
                end
            end
        end
    end

    assign ex_ctrl  = ex_c[EX_HI:EX_LO];
    assign ex_dst   = ex_d;
    assign mem_ctrl = mem_c[MEM_HI:MEM_LO];
    assign mem_dst  = mem_d;
    assign wb_ctrl  = wb_c;
    assign wb_dst   = wb_d;

    // Only a branch/jump in EX can flush, and EX holds a MULT while busy.
    a_no_flush_in_mult: assert property (@(posedge clk) disable iff (!rst_n) !(flush && mult_busy));

endmodule
